mage_dma_stream_buffer: RTL

// - One DMA channel's elastic buffer, upstream of Mage's streaming interface.
// - Input side: DMA push/full FIFO handshake. Output side: valid/ready stream into streaming_interface.
// - Counts a programmed transfer length and flags its completion.
// - Decouples DMA bursts from PEA back-pressure (pea_ready) with DEPTH words of storage.

---
 rtl/mage_dma_stream_buffer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mage_dma_stream_buffer.sv
// Elastic word buffer between one DMA channel and the PEA streaming interface.
// Tracks a programmed transfer length and pulses done_o when its last word leaves.
module mage_dma_stream_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int LEN_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       flush_i,
  input  logic [LEN_W-1:0]           cfg_len_i,
  input  logic                       dma_push_i,
  input  logic [DATA_W-1:0]          dma_data_i,
  output logic                       dma_full_o,
  output logic                       out_valid_o,
  output logic [DATA_W-1:0]          out_data_o,
  input  logic                       out_ready_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       overflow_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  in_cnt;
  logic [LEN_W-1:0]  out_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              overflow_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic push_ok;
  logic pop_ok;
  logic start_ok;
  logic last_pop;

  // Full depends only on registered state, so a pop in the same cycle never frees a slot early.
  assign dma_full_o  = (state != S_ACTIVE) || (level == LVL_W'(DEPTH)) || (in_cnt == len_q);
  assign out_valid_o = (level != '0);
  assign out_data_o  = out_valid_o ? mem[rd_ptr] : '0;
  assign busy_o      = (state == S_ACTIVE);
  assign done_o      = (state == S_DONE);
  assign overflow_o  = overflow_q;
  assign level_o     = level;

  assign push_ok  = (state == S_ACTIVE) && dma_push_i && !dma_full_o;
  assign pop_ok   = out_valid_o && out_ready_i;
  assign start_ok = (state == S_IDLE) && start_i;
  assign last_pop = pop_ok && ((out_cnt + LEN_W'(1)) == len_q);

  // NOTE: storage has no reset; level/pointers define which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= dma_data_i;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      len_q      <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow_q <= 1'b0;
    end else if (flush_i) begin
      state      <= S_IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            len_q   <= cfg_len_i;
            in_cnt  <= '0;
            out_cnt <= '0;
            state   <= (cfg_len_i == '0) ? S_DONE : S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (last_pop) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        in_cnt <= in_cnt + LEN_W'(1);
      end
      if (pop_ok) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        out_cnt <= out_cnt + LEN_W'(1);
      end

      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase

      // Overflow only counts refused pushes while a transfer is live.
      if (start_ok)
        overflow_q <= 1'b0;
      else if ((state == S_ACTIVE) && dma_push_i && dma_full_o)
        overflow_q <= 1'b1;
    end
  end

endmodule
